// File: rtl/shapool_serial_rx.sv
// Serial job receiver: syncs host data_clk/data/daisy lines onto hwclk, assembles global+daisy words, length/parity-checks and commits them.
// Latency: a shift lands SYNC_STAGES+1 hwclk after a data_clk rise; a frame commits SYNC_STAGES+2 hwclk after daisy_sel falls.
// Backpressure: load_valid holds until load_ready; a good frame arriving while blocked is dropped and sets overrun. Parity option: SHAPOOL_SERIAL_RX_PARITY_EN.
module shapool_serial_rx #(
  parameter int GLOBAL_WIDTH = 352,
  parameter int DAISY_WIDTH  = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    hwclk,
  input  logic                    reset_in,
  input  logic                    data_clk,
  input  logic                    data_in,
  input  logic                    daisy_sel,
  input  logic                    daisy_in,
  output logic                    daisy_out,
  output logic [GLOBAL_WIDTH-1:0] global_word,
  output logic [DAISY_WIDTH-1:0]  daisy_word,
  output logic                    load_valid,
  input  logic                    load_ready,
  output logic                    frame_error,
  output logic                    overrun
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef SHAPOOL_SERIAL_RX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SH_W  = GLOBAL_WIDTH + PAR_W;
  localparam int CNT_W = $clog2(GLOBAL_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(GLOBAL_WIDTH + 1);
  localparam logic [CNT_W-1:0] REQ_LEN = CNT_W'(SH_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SS-1:0][3:0] sync_q;
  logic clk_s, dat_s, sel_s, din_s;
  logic clk_prev, sel_prev;
  logic shift_en, sel_fall, shift_glb, shift_dsy;

  logic [SH_W-1:0]        g_sh;
  logic [DAISY_WIDTH-1:0] d_sh;
  logic [CNT_W-1:0]       bit_cnt;
  logic [GLOBAL_WIDTH-1:0] g_data;
  logic parity_ok, commit, len_ok, frame_ok, blocked;

  // Index 0 is the newest sample; the oldest stage feeds the edge detectors.
  assign {clk_s, dat_s, sel_s, din_s} = sync_q[SS-1];

  always_ff @(posedge hwclk or negedge reset_in) begin
    if (!reset_in) begin
      sync_q   <= '0;
      clk_prev <= 1'b0;
      sel_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SS-2:0], {data_clk, data_in, daisy_sel, daisy_in}};
      clk_prev <= clk_s;
      sel_prev <= sel_s;
    end
  end

  // Shift phase comes from the pre-edge daisy_sel, so a coincident sel fall still lands a daisy bit.
  assign shift_en  = clk_s & ~clk_prev;
  assign sel_fall  = ~sel_s & sel_prev;
  assign shift_glb = shift_en & ~sel_prev;
  assign shift_dsy = shift_en & sel_prev;

  always_ff @(posedge hwclk or negedge reset_in) begin
    if (!reset_in) begin
      g_sh    <= '0;
      d_sh    <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_glb) g_sh <= {g_sh[SH_W-2:0], dat_s};
      if (shift_dsy) d_sh <= {d_sh[DAISY_WIDTH-2:0], din_s};
      if (state_q == COMMIT) begin
        bit_cnt <= '0;
      end else if (shift_glb && (bit_cnt != CNT_SAT)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef SHAPOOL_SERIAL_RX_PARITY_EN
  // Even parity over data plus the trailing parity bit, which sits at the LSB.
  assign parity_ok = ~^g_sh;
  assign g_data    = g_sh[SH_W-1:1];
`else
  assign parity_ok = 1'b1;
  assign g_data    = g_sh;
`endif

  always_ff @(posedge hwclk or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shift_en) state_d = sel_fall ? COMMIT : SHIFT;
      SHIFT:   if (sel_fall) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign commit   = (state_q == COMMIT);
  assign len_ok   = (bit_cnt == REQ_LEN) && parity_ok;
  assign frame_ok = commit && len_ok;
  assign blocked  = load_valid && !load_ready;

  always_ff @(posedge hwclk or negedge reset_in) begin
    if (!reset_in) begin
      global_word <= '0;
      daisy_word  <= '0;
      load_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      daisy_out   <= 1'b0;
    end else begin
      daisy_out <= d_sh[DAISY_WIDTH-1];
      if (frame_ok && !blocked) begin
        global_word <= g_data;
        daisy_word  <= d_sh;
        load_valid  <= 1'b1;
      end else if (load_valid && load_ready) begin
        load_valid  <= 1'b0;
      end
      if (frame_ok && blocked)  overrun     <= 1'b1;
      if (commit && !len_ok)    frame_error <= 1'b1;
    end
  end

endmodule

// File: doc/shapool_serial_rx.md
SHAPOOL_SERIAL_RX -- requirements
Module: shapool_serial_rx

Interface
REQ-001 SHALL have parameter GLOBAL_WIDTH, default 352, bits of global job data per frame.
REQ-002 SHALL have parameter DAISY_WIDTH, default 8, bits of per-device daisy data per frame.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per async input (min 2).
REQ-004 hwclk  in  1  sole clock; all state on rising edge.
REQ-005 reset_in  in  1  reset, asynchronous assert, active-low.
REQ-006 data_clk  in  1  async serial clock from host.
REQ-007 data_in  in  1  async global serial data.
REQ-008 daisy_sel  in  1  async; 1 = daisy shift phase, 0 = global shift phase.
REQ-009 daisy_in  in  1  async daisy data from upstream device.
REQ-010 daisy_out  out  1  daisy data to downstream device.
REQ-011 global_word  out  GLOBAL_WIDTH  committed global data, first-received bit at MSB.
REQ-012 daisy_word  out  DAISY_WIDTH  committed daisy data, first-received bit at MSB.
REQ-013 load_valid  out  1  committed frame available.
REQ-014 load_ready  in  1  consumer accepts frame when high with load_valid.
REQ-015 frame_error  out  1  sticky; bad frame length (or parity) seen.
REQ-016 overrun  out  1  sticky; frame committed while previous not accepted.

Function
REQ-017 data_clk, data_in, daisy_sel, daisy_in SHALL each pass SYNC_STAGES flops; edges detected on synced values.
REQ-018 A synced data_clk rising edge SHALL shift exactly once, SYNC_STAGES+1 hwclk cycles after input edge; data_clk high and low each >= SYNC_STAGES+2 hwclk cycles.
REQ-019 On shift with daisy_sel=0: data_in into global shift reg LSB, bit counter +1, saturating at GLOBAL_WIDTH+1.
REQ-020 On shift with daisy_sel=1: daisy_in into daisy shift reg LSB; daisy_out SHALL be registered daisy shift reg MSB.
REQ-021 States: IDLE, SHIFT, COMMIT. IDLE->SHIFT on first shift; SHIFT->COMMIT on synced daisy_sel falling edge; COMMIT->IDLE next cycle.
REQ-022 In COMMIT, counter == required length: copy shift regs to outputs, set load_valid; else set frame_error, outputs unchanged.
REQ-023 Required length SHALL be GLOBAL_WIDTH (GLOBAL_WIDTH+1 with parity, see Configuration).
REQ-024 COMMIT SHALL clear bit counter; shift regs retain contents.
REQ-025 load_valid SHALL stay high, outputs stable, until cycle with load_ready=1; cleared after that cycle.
REQ-026 Valid commit while load_valid=1 and load_ready=0 same cycle: new frame dropped, overrun set; load_ready=1 same cycle: new frame accepted, load_valid stays 1, no overrun.
REQ-027 data_clk rising edge coincident with daisy_sel falling edge (synced): shift first using pre-edge daisy_sel, then COMMIT.
REQ-028 frame_error and overrun clear only on reset.

Reset
REQ-029 On reset_in low: all sync flops, shift regs, counter, global_word, daisy_word = 0; daisy_out=0; load_valid=0; frame_error=0; overrun=0; state IDLE.
REQ-030 Reset mid-frame SHALL discard partial frame; first shift after release starts new frame.

Configuration
REQ-031 Macro SHAPOOL_SERIAL_RX_PARITY_EN defined: global phase carries GLOBAL_WIDTH data bits plus one trailing even-parity bit; commit requires XOR of all GLOBAL_WIDTH+1 bits = 0, else frame_error; parity bit excluded from global_word.
REQ-032 Macro undefined: no parity bit, no parity logic; length check per REQ-022 only.

Verification
REQ-033 Send GLOBAL_WIDTH bits 0xA5.. pattern, 8 daisy bits 0x3C, drop daisy_sel -> load_valid=1, global_word matches pattern, daisy_word=0x3C.
REQ-034 Send GLOBAL_WIDTH-1 global bits then commit -> frame_error=1, load_valid=0, outputs unchanged.
REQ-035 Two valid frames, load_ready held 0 -> overrun=1, outputs hold first frame; then load_ready=1 one cycle -> load_valid=0.
REQ-036 Daisy phase 16 bits 0x12,0x34 -> daisy_out replays 0x12 delayed 8 shifts; daisy_word=0x34.
REQ-037 Assert reset_in low after 100 global bits, release, send full frame -> correct commit, no frame_error.
REQ-038 PARITY_EN defined, wrong parity bit -> frame_error=1, load_valid=0; correct parity -> commit.
